// File: rtl/cfs_algn_pkg.sv
// Shared definitions for the aligner interrupt controller: status bit indices,
// status width and a saturating-add helper for the optional error counter.
package cfs_algn_pkg;

  localparam int CFS_ALGN_IRQ_W = 5;

  typedef enum logic [2:0] {
    RX_EMPTY = 3'd0,
    RX_FULL  = 3'd1,
    TX_EMPTY = 3'd2,
    TX_FULL  = 3'd3,
    ERR      = 3'd4
  } cfs_algn_irq_idx_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'b0000000, b};
    if (sum[8]) begin
      return 8'hFF;
    end else begin
      return sum[7:0];
    end
  endfunction

endpackage

// File: rtl/cfs_algn_lvl_cnt.sv
// FIFO occupancy tracker: level counter plus single-cycle full/empty/error
// events derived from the current level and the push/pop strobes.
module cfs_algn_lvl_cnt #(
  parameter int FIFO_DEPTH = 8,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  output logic [CNT_W-1:0] lvl,
  output logic             evt_full,
  output logic             evt_empty,
  output logic             evt_err
);

  localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_M1_C = CNT_W'(FIFO_DEPTH - 1);

  logic [CNT_W-1:0] lvl_q;
  logic [CNT_W-1:0] lvl_d;

  // Simultaneous push+pop is a pass-through and never raises an event.
  always_comb begin
    lvl_d     = lvl_q;
    evt_full  = 1'b0;
    evt_empty = 1'b0;
    evt_err   = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (lvl_q == DEPTH_C) begin
          evt_err = 1'b1;
        end else begin
          lvl_d    = lvl_q + ONE_C;
          evt_full = (lvl_q == FULL_M1_C);
        end
      end
      2'b01: begin
        if (lvl_q == ZERO_C) begin
          evt_err = 1'b1;
        end else begin
          lvl_d     = lvl_q - ONE_C;
          evt_empty = (lvl_q == ONE_C);
        end
      end
      default: begin
        lvl_d = lvl_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q <= ZERO_C;
    end else begin
      lvl_q <= lvl_d;
    end
  end

  assign lvl = lvl_q;

endmodule

// File: rtl/cfs_algn_irq_ctrl.sv
// Aligner interrupt controller: sticky W1C status, masked level irq.
// Optional ERR event counter enabled by CFS_ALGN_IRQ_CTRL_ERR_CNT_EN.
module cfs_algn_irq_ctrl
  import cfs_algn_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_fifo_push,
  input  logic                      rx_fifo_pop,
  input  logic                      tx_fifo_push,
  input  logic                      tx_fifo_pop,
  input  logic [CFS_ALGN_IRQ_W-1:0] irqen,
  input  logic                      clr_valid,
  input  logic [CFS_ALGN_IRQ_W-1:0] clr_mask,
  output logic [CFS_ALGN_IRQ_W-1:0] status,
  output logic [CNT_W-1:0]          rx_lvl,
  output logic [CNT_W-1:0]          tx_lvl,
  output logic                      irq
`ifdef CFS_ALGN_IRQ_CTRL_ERR_CNT_EN
  ,
  output logic [7:0]                err_cnt
`endif
);

  logic rx_evt_full, rx_evt_empty, rx_evt_err;
  logic tx_evt_full, tx_evt_empty, tx_evt_err;

  logic [CFS_ALGN_IRQ_W-1:0] evt;
  logic [CFS_ALGN_IRQ_W-1:0] clr_eff;
  logic [CFS_ALGN_IRQ_W-1:0] status_q, status_d;
  logic                      irq_q, irq_d;

  cfs_algn_lvl_cnt #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_lvl (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_fifo_push),
    .pop       (rx_fifo_pop),
    .lvl       (rx_lvl),
    .evt_full  (rx_evt_full),
    .evt_empty (rx_evt_empty),
    .evt_err   (rx_evt_err)
  );

  cfs_algn_lvl_cnt #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_lvl (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_fifo_push),
    .pop       (tx_fifo_pop),
    .lvl       (tx_lvl),
    .evt_full  (tx_evt_full),
    .evt_empty (tx_evt_empty),
    .evt_err   (tx_evt_err)
  );

  // Set dominates clear; irq follows the post-update status so both appear together.
  always_comb begin
    evt           = {CFS_ALGN_IRQ_W{1'b0}};
    evt[RX_EMPTY] = rx_evt_empty;
    evt[RX_FULL]  = rx_evt_full;
    evt[TX_EMPTY] = tx_evt_empty;
    evt[TX_FULL]  = tx_evt_full;
    evt[ERR]      = rx_evt_err | tx_evt_err;
    clr_eff       = {CFS_ALGN_IRQ_W{clr_valid}} & clr_mask;
    status_d      = evt | (status_q & ~clr_eff);
    irq_d         = |(status_d & irqen);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= {CFS_ALGN_IRQ_W{1'b0}};
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= irq_d;
    end
  end

  assign status = status_q;
  assign irq    = irq_q;

`ifdef CFS_ALGN_IRQ_CTRL_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [1:0] err_inc;

  // A clear restarts counting from this cycle's errors rather than dropping them.
  always_comb begin
    err_inc = {1'b0, rx_evt_err} + {1'b0, tx_evt_err};
    if (clr_eff[ERR]) begin
      err_cnt_d = {6'b000000, err_inc};
    end else begin
      err_cnt_d = sat_add8(err_cnt_q, err_inc);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_cfs_algn_irq_ctrl.sv
// Self-checking bench for cfs_algn_irq_ctrl (FIFO_DEPTH=8): a behavioural model
// pushes expected outputs per cycle into a scoreboard queue, tests pop and compare.
module tb_cfs_algn_irq_ctrl;
  import cfs_algn_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_fifo_push = 1'b0, rx_fifo_pop = 1'b0;
  logic          tx_fifo_push = 1'b0, tx_fifo_pop = 1'b0;
  logic [4:0]    irqen = 5'b00000;
  logic          clr_valid = 1'b0;
  logic [4:0]    clr_mask = 5'b00000;
  logic [4:0]    status;
  logic [CW-1:0] rx_lvl, tx_lvl;
  logic          irq;
`ifdef CFS_ALGN_IRQ_CTRL_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  cfs_algn_irq_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_fifo_push (rx_fifo_push),
    .rx_fifo_pop  (rx_fifo_pop),
    .tx_fifo_push (tx_fifo_push),
    .tx_fifo_pop  (tx_fifo_pop),
    .irqen        (irqen),
    .clr_valid    (clr_valid),
    .clr_mask     (clr_mask),
    .status       (status),
    .rx_lvl       (rx_lvl),
    .tx_lvl       (tx_lvl),
    .irq          (irq)
`ifdef CFS_ALGN_IRQ_CTRL_ERR_CNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] rx;
    logic [CW-1:0] tx;
    logic [4:0]    st;
    logic          irq;
    logic [7:0]    ec;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state
  int         m_rx = 0, m_tx = 0, m_ec = 0;
  logic [4:0] m_st = 5'b00000;
  logic       m_irq = 1'b0;

  // Drive one cycle, advance the model, queue the expectation, sample after the edge.
  task automatic step(input logic rp, input logic rpo, input logic tp, input logic tpo,
                      input logic cv, input logic [4:0] cm, input logic rst);
    logic [4:0] evt;
    int errs;
    exp_t x;
    @(negedge clk);
    reset = rst; rx_fifo_push = rp; rx_fifo_pop = rpo;
    tx_fifo_push = tp; tx_fifo_pop = tpo; clr_valid = cv; clr_mask = cm;
    if (rst) begin
      m_rx = 0; m_tx = 0; m_ec = 0; m_st = 5'b00000; m_irq = 1'b0;
    end else begin
      evt = 5'b00000; errs = 0;
      if (rp && !rpo) begin
        if (m_rx == DEPTH) errs++;
        else begin if (m_rx == DEPTH - 1) evt[1] = 1'b1; m_rx++; end
      end else if (!rp && rpo) begin
        if (m_rx == 0) errs++;
        else begin if (m_rx == 1) evt[0] = 1'b1; m_rx--; end
      end
      if (tp && !tpo) begin
        if (m_tx == DEPTH) errs++;
        else begin if (m_tx == DEPTH - 1) evt[3] = 1'b1; m_tx++; end
      end else if (!tp && tpo) begin
        if (m_tx == 0) errs++;
        else begin if (m_tx == 1) evt[2] = 1'b1; m_tx--; end
      end
      evt[4] = (errs > 0);
      m_st   = evt | (m_st & ~(cv ? cm : 5'b00000));
      m_irq  = |(m_st & irqen);
      if (cv && cm[4]) m_ec = errs;
      else m_ec = (m_ec + errs > 255) ? 255 : m_ec + errs;
    end
    x.rx = CW'(m_rx); x.tx = CW'(m_tx); x.st = m_st; x.irq = m_irq; x.ec = 8'(m_ec);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0);
  endtask

  task automatic clear_all();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11111, 1'b0);
    e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b1);
    e = exp_q.pop_front();
    n_tests++;
    if (rx_lvl !== '0 || tx_lvl !== '0 || status !== 5'b00000 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rx=%0d tx=%0d st=%b irq=%b want all zero", rx_lvl, tx_lvl, status, irq);
    end
    for (int i = 0; i < 10; i++) begin
      idle();
      e = exp_q.pop_front();
      n_tests++;
      if (rx_lvl !== e.rx || status !== e.st || irq !== e.irq) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got rx=%0d st=%b irq=%b want rx=%0d st=%b irq=%b",
                 i, rx_lvl, status, irq, e.rx, e.st, e.irq);
      end
    end
  endtask

  task automatic test_rx_fill();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) irqen = 5'b00010;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0);
      e = exp_q.pop_front();
      n_tests++;
      if (rx_lvl !== e.rx || status !== e.st || irq !== e.irq) begin
        n_fail++;
        $display("FAIL rx_fill[%0d]: got rx=%0d st=%b irq=%b want rx=%0d st=%b irq=%b",
                 i, rx_lvl, status, irq, e.rx, e.st, e.irq);
      end
    end
    n_tests++;
    if (rx_lvl !== CW'(8) || status !== 5'b00010 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_full_irq: got rx=%0d st=%b irq=%b want rx=8 st=00010 irq=1", rx_lvl, status, irq);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0);
      e = exp_q.pop_front();
      n_tests++;
      if (rx_lvl !== CW'(8) || status[4] !== 1'b0 || status !== e.st) begin
        n_fail++;
        $display("FAIL full_push_pop[%0d]: got rx=%0d st=%b want rx=8 st=%b", i, rx_lvl, status, e.st);
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0);
    e = exp_q.pop_front();
    n_tests++;
    if (rx_lvl !== CW'(8) || status !== 5'b10010 || status !== e.st) begin
      n_fail++;
      $display("FAIL rx_overflow: got rx=%0d st=%b want rx=8 st=10010", rx_lvl, status);
    end
`ifdef CFS_ALGN_IRQ_CTRL_ERR_CNT_EN
    n_tests++;
    if (err_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL err_cnt_one: got %0d want 1", err_cnt);
    end
`endif
  endtask

  task automatic test_tx_empty();
    clear_all();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0);
      e = exp_q.pop_front();
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b0);
      e = exp_q.pop_front();
      n_tests++;
      if (tx_lvl !== e.tx || status !== e.st || status[2] !== (i == 2)) begin
        n_fail++;
        $display("FAIL tx_pop[%0d]: got tx=%0d st=%b want tx=%0d st=%b", i, tx_lvl, status, e.tx, e.st);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b0);
    e = exp_q.pop_front();
    n_tests++;
    if (tx_lvl !== '0 || status !== 5'b10100 || status !== e.st) begin
      n_fail++;
      $display("FAIL tx_underflow: got tx=%0d st=%b want tx=0 st=10100", tx_lvl, status);
    end
  endtask

  task automatic test_clear();
    clear_all();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0);
    e = exp_q.pop_front();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0);
    e = exp_q.pop_front();
    n_tests++;
    if (status !== 5'b00010 || irq !== 1'b1 || irq !== e.irq) begin
      n_fail++;
      $display("FAIL refill_full: got st=%b irq=%b want st=00010 irq=1", status, irq);
    end
    irqen = 5'b00000;
    idle();
    e = exp_q.pop_front();
    n_tests++;
    if (irq !== 1'b0 || status !== 5'b00010) begin
      n_fail++;
      $display("FAIL irqen_mask: got st=%b irq=%b want st=00010 irq=0", status, irq);
    end
    irqen = 5'b00010;
    idle();
    e = exp_q.pop_front();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00010, 1'b0);
    e = exp_q.pop_front();
    n_tests++;
    if (status !== 5'b00000 || irq !== 1'b0 || status !== e.st) begin
      n_fail++;
      $display("FAIL w1c_clear: got st=%b irq=%b want st=00000 irq=0", status, irq);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010, 1'b0);
    e = exp_q.pop_front();
    n_tests++;
    if (status !== 5'b00000) begin
      n_fail++;
      $display("FAIL clr_ignored_pop: got st=%b want 00000", status);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00010, 1'b0);
    e = exp_q.pop_front();
    n_tests++;
    if (status !== 5'b00010 || irq !== 1'b1 || status !== e.st) begin
      n_fail++;
      $display("FAIL set_beats_clear: got st=%b irq=%b want st=00010 irq=1", status, irq);
    end
  endtask

  task automatic test_err_dual();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0);
      e = exp_q.pop_front();
    end
    n_tests++;
    if (rx_lvl !== '0 || tx_lvl !== CW'(8) || status !== 5'b01011) begin
      n_fail++;
      $display("FAIL swap_levels: got rx=%0d tx=%0d st=%b want rx=0 tx=8 st=01011", rx_lvl, tx_lvl, status);
    end
    clear_all();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0);
    e = exp_q.pop_front();
    n_tests++;
    if (status !== 5'b10000 || rx_lvl !== '0 || tx_lvl !== CW'(8)) begin
      n_fail++;
      $display("FAIL dual_err: got st=%b rx=%0d tx=%0d want st=10000 rx=0 tx=8", status, rx_lvl, tx_lvl);
    end
`ifdef CFS_ALGN_IRQ_CTRL_ERR_CNT_EN
    n_tests++;
    if (err_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL err_cnt_two: got %0d want 2", err_cnt);
    end
`endif
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0);
      e = exp_q.pop_front();
    end
`ifdef CFS_ALGN_IRQ_CTRL_ERR_CNT_EN
    n_tests++;
    if (err_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL err_cnt_sat: got %0d want 255", err_cnt);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b10000, 1'b0);
    e = exp_q.pop_front();
    n_tests++;
    if (err_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL err_cnt_clr_evt: got %0d want 1", err_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b1);
    e = exp_q.pop_front();
    irqen = 5'b00001;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0); e = exp_q.pop_front();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0); e = exp_q.pop_front();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0); e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0);
      e = exp_q.pop_front();
    end
    n_tests++;
    if (rx_lvl !== CW'(5) || status !== 5'b10001 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got rx=%0d st=%b irq=%b want rx=5 st=10001 irq=1", rx_lvl, status, irq);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b1);
    e = exp_q.pop_front();
    n_tests++;
    if (rx_lvl !== '0 || tx_lvl !== '0 || status !== 5'b00000 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got rx=%0d tx=%0d st=%b irq=%b want all zero", rx_lvl, tx_lvl, status, irq);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0);
    e = exp_q.pop_front();
    n_tests++;
    if (rx_lvl !== CW'(1) || status !== 5'b00000 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_push: got rx=%0d st=%b irq=%b want rx=1 st=00000 irq=0", rx_lvl, status, irq);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) irqen = 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
           ($urandom_range(0, 99) == 0));
      e = exp_q.pop_front();
      n_tests++;
      if (rx_lvl !== e.rx || tx_lvl !== e.tx || status !== e.st || irq !== e.irq
`ifdef CFS_ALGN_IRQ_CTRL_ERR_CNT_EN
          || err_cnt !== e.ec
`endif
         ) begin
        n_fail++;
        $display("FAIL random[%0d]: got rx=%0d tx=%0d st=%b irq=%b want rx=%0d tx=%0d st=%b irq=%b",
                 i, rx_lvl, tx_lvl, status, irq, e.rx, e.tx, e.st, e.irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rx_fill();
    test_full_push_pop();
    test_tx_empty();
    test_clear();
    test_err_dual();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
